// File: rtl/mix_act_forward.sv
// Hard-tanh activation stage for the mixer layers: captures one hidden vector,
// activates it chunk by chunk into q/grad_mask and streams each chunk to the activation buffer.
module mix_act_forward #(
    parameter int DATA_N     = 8,
    parameter int HID_DIM    = 32,
    parameter int N_LEN      = 16,
    parameter int FRAC       = 10,
    parameter int ADDR_WIDTH = 9,
    parameter int STATE_LEN  = 4,
    parameter logic [STATE_LEN-1:0] F_MIX1 = STATE_LEN'(1),
    parameter logic [STATE_LEN-1:0] F_MIX2 = STATE_LEN'(2),
    parameter logic [STATE_LEN-1:0] F_MIX3 = STATE_LEN'(3)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [STATE_LEN-1:0]      state,
    input  logic                      d_valid,
    input  logic [HID_DIM*N_LEN-1:0]  d,
    output logic                      valid,
    output logic [HID_DIM*N_LEN-1:0]  q,
    output logic [HID_DIM-1:0]        grad_mask,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [DATA_N*N_LEN-1:0]   wdata
);

    localparam int NCHUNK  = HID_DIM / DATA_N;
    localparam int CW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_W = DATA_N * N_LEN;
    localparam logic [CW-1:0] LAST_C = CW'(NCHUNK - 1);
    localparam logic signed [N_LEN-1:0] ONE     = N_LEN'(2 ** FRAC);
    localparam logic signed [N_LEN-1:0] NEG_ONE = -ONE;

    typedef enum logic [1:0] {IDLE, PROC, DONE} fsm_t;

    fsm_t                      cur_st, nxt_st;
    logic [CW-1:0]             c;
    logic [HID_DIM*N_LEN-1:0]  in_buf;
    logic [ADDR_WIDTH-1:0]     base;
    logic                      wr_ok;
    logic                      capture, process, finish;
    logic [CHUNK_W-1:0]        act_chunk;
    logic [DATA_N-1:0]         mask_chunk;
    logic signed [N_LEN-1:0]   elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_st <= IDLE;
        else        cur_st <= nxt_st;
    end

    // Dropping run wins over everything, including a simultaneous d_valid.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE:    if (run && d_valid) nxt_st = PROC;
            PROC:    if (c == LAST_C)    nxt_st = DONE;
            DONE:    nxt_st = DONE;
            default: nxt_st = IDLE;
        endcase
        if (!run) nxt_st = IDLE;
    end

    always_comb begin
        capture = (cur_st == IDLE) && run && d_valid;
        process = (cur_st == PROC) && run;
        finish  = (cur_st == DONE) && run;
    end

    always_comb begin
        act_chunk  = '0;
        mask_chunk = '0;
        elem       = '0;
        for (int j = 0; j < DATA_N; j++) begin
            elem = in_buf[(int'(c) * DATA_N + j) * N_LEN +: N_LEN];
            if (elem > ONE)          act_chunk[j*N_LEN +: N_LEN] = ONE;
            else if (elem < NEG_ONE) act_chunk[j*N_LEN +: N_LEN] = NEG_ONE;
            else                     act_chunk[j*N_LEN +: N_LEN] = elem;
            mask_chunk[j] = (elem >= NEG_ONE) && (elem <= ONE);
        end
    end

    // Buffer base and write permission are latched with d so a later state change cannot redirect writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            in_buf    <= '0;
            base      <= '0;
            wr_ok     <= 1'b0;
            valid     <= 1'b0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            q         <= '0;
            grad_mask <= '0;
        end else if (!run) begin
            c         <= '0;
            valid     <= 1'b0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            q         <= '0;
            grad_mask <= '0;
        end else begin
            we <= 1'b0;
            if (capture) begin
                in_buf <= d;
                c      <= '0;
                case (state)
                    F_MIX1:  begin base <= ADDR_WIDTH'(0); wr_ok <= 1'b1; end
                    F_MIX2:  begin base <= ADDR_WIDTH'(4); wr_ok <= 1'b1; end
                    F_MIX3:  begin base <= ADDR_WIDTH'(8); wr_ok <= 1'b1; end
                    default: begin base <= ADDR_WIDTH'(0); wr_ok <= 1'b0; end
                endcase
            end
            if (process) begin
                q[int'(c) * CHUNK_W +: CHUNK_W]       <= act_chunk;
                grad_mask[int'(c) * DATA_N +: DATA_N] <= mask_chunk;
                we    <= wr_ok;
                waddr <= base + ADDR_WIDTH'(c);
                wdata <= act_chunk;
                c     <= c + 1'b1;
            end
            if (finish) valid <= 1'b1;
        end
    end

endmodule

// File: doc/mix_act_forward.md
MIX_ACT_FORWARD -- requirements
Module: mix_act_forward

Interface
REQ-001 The block SHALL have parameters as follows:
  - DATA_N, default 8: elements per chunk.
  - HID_DIM, default 32 (=4*DATA_N): vector length.
  - N_LEN, default 16: signed element width.
  - FRAC, default 10: fraction bits.
  - ADDR_WIDTH, default 9: buffer address width.
  - STATE_LEN, default from consts_train.vh: state code width.
REQ-002 The block SHALL have ports as follows:
  - clk  input  1  clock; all logic rising-edge.
  - rst_n  input  1  reset, asynchronous, active-low.
  - run  input  1  stage enable; low aborts and clears.
  - state  input  STATE_LEN  current layer code (F_MIX1/F_MIX2/F_MIX3).
  - d_valid  input  1  d holds a complete mix_forward result.
  - d  input  HID_DIM*N_LEN  input vector; element i at bits [i*N_LEN +: N_LEN], signed two's complement.
  - valid  output  1  q and grad_mask complete.
  - q  output  HID_DIM*N_LEN  activated vector, same packing as d.
  - grad_mask  output  HID_DIM  per-element derivative mask.
  - we  output  1  activation-buffer write enable.
  - waddr  output  ADDR_WIDTH  buffer word address.
  - wdata  output  DATA_N*N_LEN  one chunk of activated elements.

Function
REQ-003 The activation SHALL be hard-tanh with ONE = 2^FRAC:
  - y = ONE when x > ONE.
  - y = -ONE when x < -ONE.
  - y = x otherwise.
  - Comparisons are signed, full N_LEN width; no overflow.
REQ-004 The mask SHALL be grad_mask[i] = 1 iff -ONE <= x_i <= ONE; boundary values ±ONE give mask 1.
REQ-005 The FSM SHALL have exactly three states: IDLE, PROC, DONE.
REQ-006 In IDLE with run=1 and d_valid=1, the block SHALL register d into an internal HID_DIM*N_LEN buffer, set chunk counter c=0, and go to PROC.
REQ-007 In PROC, each cycle SHALL process chunk c (elements c*DATA_N .. c*DATA_N+DATA_N-1) from the registered buffer:
  - Write the activated chunk into q slice c and the mask into grad_mask slice c.
  - Drive we=1, waddr=base+c, wdata=activated chunk, all registered in the same cycle.
  - Increment c.
REQ-008 PROC SHALL last exactly 4 cycles; after c=3 the FSM SHALL go to DONE.
REQ-009 Base address SHALL be 0 for F_MIX1, 4 for F_MIX2, 8 for F_MIX3, sampled when d is captured.
REQ-010 For any other state code, we SHALL stay 0 for the whole operation, while q, grad_mask and valid are still produced normally.
REQ-011 In DONE, valid SHALL be 1, we SHALL be 0, and q and grad_mask SHALL hold stable until run=0.
REQ-012 Latency: with d_valid sampled at edge T, we SHALL be high after edges T+1..T+4, and valid SHALL rise after edge T+5.
REQ-013 d_valid asserted in PROC or DONE SHALL be ignored; the captured buffer SHALL NOT change.
REQ-014 run=0 in any state SHALL, at the next edge:
  - Return the FSM to IDLE.
  - Clear valid, we, q, grad_mask, waddr and c.
  - Abort any in-progress PROC with no further writes.
REQ-015 run=1 with d_valid=0 in IDLE SHALL hold IDLE with all outputs 0.
REQ-016 Simultaneous run deassert and d_valid SHALL be handled as deassert only: no capture.
REQ-017 A new operation SHALL require leaving DONE via run=0; there is no back-to-back restart from DONE.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force:
  - FSM to IDLE.
  - c, valid, we, waddr, wdata, q, grad_mask and the input buffer to 0.
REQ-019 Reset asserted mid-PROC SHALL abort with no further we pulses after release, until a new d_valid.

Verification
REQ-020 Basic pass, FRAC=10, state=F_MIX2:
  - Stimulus: all elements 0x0200 (0.5).
  - Required: we high 4 cycles, waddr 4,5,6,7; q all 0x0200; grad_mask all 1; valid at T+5.
REQ-021 Saturation:
  - Stimulus: elements alternating 0x1000 / 0xF000 (±4.0).
  - Required: q alternating 0x0400 / 0xFC00; grad_mask all 0.
REQ-022 Boundaries:
  - Stimulus: elements 0x0400, 0xFC00, 0x0401, 0xFBFF.
  - Required: q = 0x0400, 0xFC00, 0x0400, 0xFC00; mask = 1, 1, 0, 0.
REQ-023 Abort and relaunch:
  - Stimulus: run dropped after the second write.
  - Required: no third write; valid never rises; q = 0 next cycle; a relaunch after run=1 with F_MIX3 writes addresses 8..11.
REQ-024 Ignored input and invalid state:
  - Stimulus: d changed with d_valid=1 during PROC.
  - Required: q reflects the originally captured d.
  - Stimulus: state = non-MIX code.
  - Required: we stays 0 and valid still rises at T+5.
REQ-025 Reset mid-PROC:
  - Stimulus: rst_n pulsed low during PROC.
  - Required: all outputs 0 immediately (asynchronous); no we after release.
